regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning register count; ADDR_W = clog2(NUM_REGS) is derived.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of read ports.
REQ-004 SHALL have parameter NUM_WR, default 2, meaning number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding is enabled.
REQ-006 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port rd_en  input  NUM_RD  per-port read enable.
REQ-009 SHALL have port rd_addr  input  NUM_RD x ADDR_W  per-port read index.
REQ-010 SHALL have port rd_data  output  NUM_RD x DATA_W  registered read data.
REQ-011 SHALL have port rd_busy  output  NUM_RD  registered busy flag of the register that was read.
REQ-012 SHALL have port wr_en  input  NUM_WR  per-port write enable.
REQ-013 SHALL have port wr_addr  input  NUM_WR x ADDR_W  per-port write index.
REQ-014 SHALL have port wr_data  input  NUM_WR x DATA_W  per-port write data.
REQ-015 SHALL have port claim_en  input  1  marks a destination register busy (instruction issued).
REQ-016 SHALL have port claim_addr  input  ADDR_W  register to claim.
REQ-017 SHALL have port flush  input  1  clears all busy bits (pipeline flush).
REQ-018 SHALL have port busy_count  output  ADDR_W+1  registered number of busy registers.

Function
REQ-019 SHALL make register 0 read as zero, ignore writes to it, and never mark it busy.
REQ-020 SHALL give read latency 1: rd_data[p] and rd_busy[p] update at the edge after rd_en[p] is sampled high.
REQ-021 SHALL hold rd_data[p] and rd_busy[p] unchanged while rd_en[p] is low.
REQ-022 SHALL resolve two enabled write ports with the same wr_addr in favour of the highest-indexed port.
REQ-023 SHALL, when BYPASS=1, return the winning same-cycle wr_data for a read whose address matches an enabled write.
REQ-024 SHALL, when BYPASS=0, return the pre-write contents in that same-cycle match case.
REQ-025 SHALL set busy[claim_addr] at the edge where claim_en is high.
REQ-026 SHALL clear busy[a] at the edge where any enabled write port targets a.
REQ-027 SHALL keep busy set when a claim and a write target the same register in the same cycle (claim wins).
REQ-028 SHALL clear all busy bits on flush, with flush taking priority over a same-cycle claim; register data is unaffected.
REQ-029 SHALL drive rd_busy[p] with the next-state busy bit of rd_addr[p], i.e. after this cycle's claim/write/flush updates.
REQ-030 SHALL keep busy_count equal to the population count of the registered busy vector at all times.
REQ-031 SHALL bound busy_count to the range 0 to NUM_REGS-1 (register 0 is excluded).
REQ-032 SHALL treat an out-of-range address (at or above NUM_REGS) as a read of zero, not busy, and a write/claim no-op.

Reset
REQ-033 SHALL, on reset, clear all registers, all busy bits, rd_data, rd_busy and busy_count to 0.
REQ-034 SHALL give reset priority over every same-cycle write, claim, flush and read.

Structure
REQ-035 SHALL place reg_data_t, reg_index_t, REG_ZERO and REG_ZERO_VAL in the shared core package.
REQ-036 SHALL implement the busy vector and busy_count in one sub-module, regfile_scoreboard.
REQ-037 SHALL implement storage and bypass muxing in the top level.

Verification
REQ-038 SHALL cover: write x5=0xDEADBEEF, then read x5 on port 0 the next cycle -> rd_data[0]=0xDEADBEEF one cycle later.
REQ-039 SHALL cover: wr0 and wr1 both target x7 with 0x11 and 0x22 in one cycle -> x7 reads 0x22.
REQ-040 SHALL cover: write x3=0x55 while reading x3 in the same cycle -> rd_data=0x55 with BYPASS=1, and the old value 0 with BYPASS=0.
REQ-041 SHALL cover: claim x9, then one cycle later claim x9 and write x9 together -> busy stays 1 and busy_count=1.
REQ-042 SHALL cover: claim x1, x2 and x4 on consecutive cycles, then flush together with a claim of x6 -> busy_count goes 3 then 0, and rd_busy for x6 is 0.
REQ-043 SHALL cover: write x0=0xFFFFFFFF, claim x0, then apply reset during a write to x8 -> x0 reads 0, busy_count=0, x8 reads 0 after reset.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared core types and constants for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int CORE_DATA_W = 32;
  localparam int CORE_ADDR_W = 5;

  typedef logic [CORE_DATA_W-1:0] reg_data_t;
  typedef logic [CORE_ADDR_W-1:0] reg_index_t;

  localparam reg_index_t REG_ZERO     = '0;
  localparam reg_data_t  REG_ZERO_VAL = '0;

  // Indices may exceed the register count when NUM_REGS is not a power of two.
  function automatic logic index_ok(input int unsigned idx, input int unsigned count);
    return idx < count;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: claim sets, write clears, flush clears all, claim beats write.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_WR   = 2,
  parameter int ADDR_W   = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           claim_en,
  input  logic [ADDR_W-1:0]              claim_addr,
  input  logic                           flush,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
  output logic [NUM_REGS-1:0]            busy_next,
  output logic [ADDR_W:0]                busy_count
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [NUM_REGS-1:0] busy;

  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
    return cnt;
  endfunction

  always_comb begin
    busy_next = busy;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && index_ok(32'(wr_addr[w]), 32'(NUM_REGS))) busy_next[wr_addr[w]] = 1'b0;
    end
    if (claim_en && index_ok(32'(claim_addr), 32'(NUM_REGS)) && claim_addr != ZERO_IDX)
      busy_next[claim_addr] = 1'b1;
    if (flush) busy_next = '0;
    busy_next[0] = 1'b0;
  end

  // Count is registered from the same next-state vector so it always matches busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= popcount(busy_next);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with x0 hardwired to zero, optional write-to-read bypass and busy scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int  DATA_W   = 32,
  parameter int  NUM_REGS = 32,
  parameter int  NUM_RD   = 2,
  parameter int  NUM_WR   = 2,
  parameter int  BYPASS   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
  input  logic                           claim_en,
  input  logic [ADDR_W-1:0]              claim_addr,
  input  logic                           flush,
  output logic [ADDR_W:0]                busy_count
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
  localparam logic [DATA_W-1:0] ZERO_VAL = DATA_W'(REG_ZERO_VAL);

  logic [DATA_W-1:0]             regs [NUM_REGS];
  logic [NUM_REGS-1:0]           busy_next;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_val;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return index_ok(32'(a), 32'(NUM_REGS));
  endfunction

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return in_range(a) && (a != ZERO_IDX);
  endfunction

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy_next  (busy_next),
    .busy_count (busy_count)
  );

  // Ascending port order: the last non-blocking write, from the highest port, wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= ZERO_VAL;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && writable(wr_addr[w])) regs[wr_addr[w]] <= wr_data[w];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_val[p] = ZERO_VAL;
      if (writable(rd_addr[p])) begin
        rd_val[p] = regs[rd_addr[p]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wr_addr[w] == rd_addr[p]) rd_val[p] = wr_data[w];
          end
        end
      end
    end
  end

  // Read stage: one-cycle latency, outputs hold while the port is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          rd_data[p] <= rd_val[p];
          rd_busy[p] <= in_range(rd_addr[p]) ? busy_next[rd_addr[p]] : 1'b0;
        end
      end
    end
  end

endmodule
